// File: rtl/ror_seq_op.sv
`default_nettype none
// ============================================================================
//  Module      : ror_seq_op
//  Description : Multi-cycle rotate-right unit, at most STEP bit positions per
//                clock, with a start/busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module ror_seq_op #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   numOfRotateBits,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    localparam logic [SHW-1:0] c_step = SHW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [SHW-1:0]   w_k;
    logic [SHW-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0] w_rot;
    logic             w_accept;

    // Requests arriving while an operation is in flight are dropped, not queued.
    assign w_accept  = start && (r_state != S_RUN);
    assign w_k       = (r_cnt < c_step) ? r_cnt : c_step;
    assign w_cnt_nxt = r_cnt - w_k;
    assign w_rot     = (r_work >> w_k) | (r_work << (WIDTH - int'(w_k)));

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = (numOfRotateBits == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_cnt_nxt == '0)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (w_accept)
                    w_state_nxt = (numOfRotateBits == '0) ? S_DONE : S_RUN;
                else
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            data_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_work <= data_in;
                r_cnt  <= numOfRotateBits;
                if (numOfRotateBits == '0)
                    data_out <= data_in;
            end else if (r_state == S_RUN) begin
                r_work <= w_rot;
                r_cnt  <= w_cnt_nxt;
                // Only the final rotated value is ever published.
                if (w_cnt_nxt == '0)
                    data_out <= w_rot;
            end
        end
    end

endmodule
`default_nettype wire
